// File: rtl/alu_sequencer.sv
// alu_sequencer: initiator-side controller for the 8-bit 6502 datapath ALU.
// Accepts one request per start handshake, drives operands and one-hot
// operation strobes for one ISSUE cycle, reads the registered ALU result
// back off SB or ADL, and returns the result with N/Z/C(/V) flags.
// Optional feature macro: ALU_SEQ_VFLAG_EN builds the overflow (V) flag;
// without it flag_v is tied low.
module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       dec,
  input  logic [7:0] a_val,
  input  logic [7:0] b_val,
  input  logic       carry_in,
  input  logic       dst_sel,
  input  logic [7:0] alu_sb,
  input  logic [7:0] alu_adl,
  input  logic       alu_cout,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  output logic       sums,
  output logic       subs,
  output logic       ands,
  output logic       eors,
  output logic       ors,
  output logic       shftr,
  output logic       shftcr,
  output logic       dec_en,
  output logic       alu_clr,
  output logic       adloa,
  output logic       sboa,
  output logic [7:0] result,
  output logic       flag_n,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_v,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_LATCH = 3'd2,
    S_ISSUE = 3'd3,
    S_READ  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADC = 3'd0;
  localparam logic [2:0] OP_SBC = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_EOR = 3'd3;
  localparam logic [2:0] OP_ORA = 3'd4;
  localparam logic [2:0] OP_LSR = 3'd5;
  localparam logic [2:0] OP_ROR = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  state_t     r_state;
  state_t     w_nextState;

  // r_live is low while reset is held and for the partial cycle after
  // release, so INIT's clear pulse covers exactly one full clock cycle and
  // every output reads 0 while reset is active.
  logic       r_live;

  logic [2:0] r_op;
  logic       r_dec;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_cin;
  logic       r_dstSel;
  logic       r_cout;

  logic [7:0] r_result;
  logic       r_flagN;
  logic       r_flagZ;
  logic       r_flagC;

  logic [7:0] w_bus;
  logic       w_carryNext;
  logic       w_isShift;

  // State register; reset parks the sequencer in INIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Marks the first clock edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // Next-state and per-state ALU control outputs.
  always_comb begin
    w_nextState = r_state;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_cin     = 1'b0;
    sums        = 1'b0;
    subs        = 1'b0;
    ands        = 1'b0;
    eors        = 1'b0;
    ors         = 1'b0;
    shftr       = 1'b0;
    shftcr      = 1'b0;
    dec_en      = 1'b0;
    alu_clr     = 1'b0;
    adloa       = 1'b0;
    sboa        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    busy        = r_live && (r_state != S_IDLE);
    case (r_state)
      S_INIT: begin
        alu_clr = r_live;
        if (r_live) begin
          w_nextState = S_IDLE;
        end
      end
      S_IDLE: begin
        if (start) begin
          w_nextState = S_LATCH;
        end
      end
      S_LATCH: begin
        if (r_op == OP_ILL) begin
          w_nextState = S_FIN;
        end else begin
          w_nextState = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_nextState = S_READ;
        alu_a       = r_a;
        alu_b       = w_isShift ? 8'h00 : r_b;
        alu_cin     = (r_op == OP_ROR) ? r_cin : 1'b0;
        dec_en      = r_dec && (r_op == OP_ADC);
        case (r_op)
          OP_ADC:  sums   = 1'b1;
          OP_SBC:  subs   = 1'b1;
          OP_AND:  ands   = 1'b1;
          OP_EOR:  eors   = 1'b1;
          OP_ORA:  ors    = 1'b1;
          OP_LSR:  shftr  = 1'b1;
          OP_ROR:  shftcr = 1'b1;
          default: sums   = 1'b0;
        endcase
      end
      S_READ: begin
        w_nextState = S_FIN;
        sboa        = ~r_dstSel;
        adloa       = r_dstSel;
      end
      S_FIN: begin
        w_nextState = S_IDLE;
        done        = 1'b1;
        err         = (r_op == OP_ILL);
      end
      default: begin
        w_nextState = S_INIT;
      end
    endcase
  end

  // Request capture at the accepting edge so later input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op     <= 3'd0;
      r_dec    <= 1'b0;
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_cin    <= 1'b0;
      r_dstSel <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_op     <= op;
      r_dec    <= dec;
      r_a      <= a_val;
      r_b      <= b_val;
      r_cin    <= carry_in;
      r_dstSel <= dst_sel;
    end
  end

  // ALU carry out is only meaningful while the strobes are up, so grab it at the end of ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cout <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      r_cout <= alu_cout;
    end
  end

  // Readback bus selection and carry-flag rule per operation.
  always_comb begin
    w_isShift   = (r_op == OP_LSR) || (r_op == OP_ROR);
    w_bus       = r_dstSel ? alu_adl : alu_sb;
    w_carryNext = r_flagC;
    case (r_op)
      OP_ADC:  w_carryNext = r_cout;
      OP_SBC:  w_carryNext = ~r_cout;
      OP_LSR:  w_carryNext = r_cout;
      OP_ROR:  w_carryNext = r_cout;
      OP_AND:  w_carryNext = r_flagC;
      OP_EOR:  w_carryNext = r_flagC;
      OP_ORA:  w_carryNext = r_flagC;
      default: w_carryNext = r_flagC;
    endcase
  end

  // Result and N/Z/C update on the READ->FIN edge; illegal ops never pass READ so they leave these untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= 8'h00;
      r_flagN  <= 1'b0;
      r_flagZ  <= 1'b0;
      r_flagC  <= 1'b0;
    end else if (r_state == S_READ) begin
      r_result <= w_bus;
      r_flagN  <= w_bus[7];
      r_flagZ  <= (w_bus == 8'h00);
      r_flagC  <= w_carryNext;
    end
  end

`ifdef ALU_SEQ_VFLAG_EN
  logic r_flagV;
  logic w_vNext;

  // Signed overflow from operand and result sign bits; only ADC/SBC touch V.
  always_comb begin
    w_vNext = r_flagV;
    case (r_op)
      OP_ADC:  w_vNext = (r_a[7] == r_b[7]) && (w_bus[7] != r_a[7]);
      OP_SBC:  w_vNext = (r_a[7] != r_b[7]) && (w_bus[7] != r_a[7]);
      default: w_vNext = r_flagV;
    endcase
  end

  // Overflow flag register, updated alongside the other flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flagV <= 1'b0;
    end else if (r_state == S_READ) begin
      r_flagV <= w_vNext;
    end
  end

  assign flag_v = r_flagV;
`else
  assign flag_v = 1'b0;
`endif

  assign result = r_result;
  assign flag_n = r_flagN;
  assign flag_z = r_flagZ;
  assign flag_c = r_flagC;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer with a simple
// behavioural ALU attached and an arithmetic reference model for the
// expected result and flags. Honours ALU_SEQ_VFLAG_EN for the V flag.
module tb_alu_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic       dec;
  logic [7:0] a_val;
  logic [7:0] b_val;
  logic       carry_in;
  logic       dst_sel;
  logic [7:0] alu_sb;
  logic [7:0] alu_adl;
  logic       alu_cout;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_cin;
  logic       sums, subs, ands, eors, ors, shftr, shftcr;
  logic       dec_en;
  logic       alu_clr;
  logic       adloa;
  logic       sboa;
  logic [7:0] result;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       busy;
  logic       done;
  logic       err;

  int tests  = 0;
  int failed = 0;

  logic [7:0] mRes;
  logic       mN, mZ, mC, mV;

  logic [2:0] rOp;
  logic       rDec;
  logic [7:0] rA;
  logic [7:0] rB;

  logic [6:0] strobes;
  assign strobes = {sums, subs, ands, eors, ors, shftr, shftcr};

  alu_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dec      (dec),
    .a_val    (a_val),
    .b_val    (b_val),
    .carry_in (carry_in),
    .dst_sel  (dst_sel),
    .alu_sb   (alu_sb),
    .alu_adl  (alu_adl),
    .alu_cout (alu_cout),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .sums     (sums),
    .subs     (subs),
    .ands     (ands),
    .eors     (eors),
    .ors      (ors),
    .shftr    (shftr),
    .shftcr   (shftcr),
    .dec_en   (dec_en),
    .alu_clr  (alu_clr),
    .adloa    (adloa),
    .sboa     (sboa),
    .result   (result),
    .flag_n   (flag_n),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: combinational carry out while strobed, result stored on the strobed edge.
  function automatic logic [8:0] aluEval(input logic [6:0] s, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci, input logic de);
    logic [4:0] lo;
    logic [4:0] hi;
    logic [8:0] r;
    r = 9'h000;
    if (s[6]) begin
      if (de) begin
        lo = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        if (lo > 5'd9) lo = lo + 5'd6;
        hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, lo[4]};
        if (hi > 5'd9) hi = hi + 5'd6;
        r = {hi[4], hi[3:0], lo[3:0]};
      end else begin
        r = {1'b0, a} + {1'b0, b};
      end
    end else if (s[5]) begin
      r = {(a < b), a - b};
    end else if (s[4]) begin
      r = {1'b0, a & b};
    end else if (s[3]) begin
      r = {1'b0, a ^ b};
    end else if (s[2]) begin
      r = {1'b0, a | b};
    end else if (s[1]) begin
      r = {a[0], 1'b0, a[7:1]};
    end else if (s[0]) begin
      r = {a[0], ci, a[7:1]};
    end
    return r;
  endfunction

  logic [8:0] aluNow;
  logic [7:0] aluReg;
  assign aluNow   = aluEval(strobes, alu_a, alu_b, alu_cin, dec_en);
  assign alu_cout = aluNow[8];
  assign alu_sb   = sboa  ? aluReg : 8'h5A;
  assign alu_adl  = adloa ? aluReg : 8'hA5;

  // ALU output register loads whenever any operation strobe is up.
  always @(posedge clk) begin
    if (strobes != 7'd0) aluReg <= aluNow[7:0];
  end

  initial aluReg = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operation's definition.
  task automatic refModel(input logic [2:0] tOp, input logic tDec, input logic [7:0] tA,
                          input logic [7:0] tB, input logic tCin);
    int ia, ib, s, sa, sb;
    logic [7:0] r;
    ia = int'(tA);
    ib = int'(tB);
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    r  = mRes;
    case (tOp)
      3'd0: begin
        if (tDec) begin
          s  = (ia / 16) * 10 + ia % 16 + (ib / 16) * 10 + ib % 16;
          mC = (s > 99);
          s  = s % 100;
          r  = 8'((s / 10) * 16 + s % 10);
        end else begin
          s  = ia + ib;
          mC = (s > 255);
          r  = 8'(s % 256);
        end
      end
      3'd1: begin
        r  = 8'((ia - ib + 256) % 256);
        mC = (ia >= ib);
      end
      3'd2: r = tA & tB;
      3'd3: r = tA ^ tB;
      3'd4: r = tA | tB;
      3'd5: begin
        r  = 8'(ia / 2);
        mC = (ia % 2) == 1;
      end
      3'd6: begin
        r  = 8'(ia / 2 + (tCin ? 128 : 0));
        mC = (ia % 2) == 1;
      end
      default: r = mRes;
    endcase
`ifdef ALU_SEQ_VFLAG_EN
    if (tOp == 3'd0) begin
      if (tDec) mV = (tA[7] == tB[7]) && (r[7] != tA[7]);
      else      mV = ((sa + sb) > 127) || ((sa + sb) < -128);
    end else if (tOp == 3'd1) begin
      mV = ((sa - sb) > 127) || ((sa - sb) < -128);
    end
`else
    sa = sa + sb;
`endif
    if (tOp != 3'd7) begin
      mRes = r;
      mN   = r[7];
      mZ   = (r == 8'h00);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] tOp, input logic tDec, input logic [7:0] tA,
                               input logic [7:0] tB, input logic tCin, input logic tDst,
                               input logic tPoke);
    logic [6:0] expStrobe;
    refModel(tOp, tDec, tA, tB, tCin);
    expStrobe = 7'b1000000 >> tOp;
    @(negedge clk);
    op = tOp; dec = tDec; a_val = tA; b_val = tB; carry_in = tCin; dst_sel = tDst;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    op       = 3'($urandom);
    dec      = 1'($urandom);
    a_val    = 8'($urandom);
    b_val    = 8'($urandom);
    carry_in = ~tCin;
    dst_sel  = ~tDst;
    checkOutput("latch_busy", busy, 1);
    checkOutput("latch_strobes", {strobes, dec_en, sboa, adloa, done}, 0);
    if (tOp != 3'd7) begin
      @(posedge clk); #1;
      checkOutput("issue_strobes", strobes, expStrobe);
      checkOutput("issue_dec_en", dec_en, tDec && (tOp == 3'd0));
      checkOutput("issue_alu_a", alu_a, tA);
      if (tOp < 3'd5) checkOutput("issue_alu_b", alu_b, tB);
      if (tOp == 3'd6) checkOutput("issue_alu_cin", alu_cin, tCin);
      checkOutput("issue_enables", {sboa, adloa, done}, 0);
      if (tPoke) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("read_enables", {sboa, adloa}, {~tDst, tDst});
      checkOutput("read_strobes", {strobes, dec_en, done}, 0);
    end
    @(posedge clk); #1;
    checkOutput("fin_done", done, 1);
    checkOutput("fin_err", err, (tOp == 3'd7));
    checkOutput("fin_result", result, mRes);
    checkOutput("fin_flags_nzcv", {flag_n, flag_z, flag_c, flag_v}, {mN, mZ, mC, mV});
    checkOutput("fin_quiet", {strobes, sboa, adloa}, 0);
    @(posedge clk); #1;
    checkOutput("idle_after_fin", {busy, done, err}, 0);
    if (tPoke) begin
      @(posedge clk); #1;
      checkOutput("start_in_issue_ignored", busy, 0);
    end
  endtask

  // Safety net so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; dec = 1'b0; a_val = 8'h00; b_val = 8'h00;
    carry_in = 1'b0; dst_sel = 1'b0;
    mRes = 8'h00; mN = 1'b0; mZ = 1'b0; mC = 1'b0; mV = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {result, flag_n, flag_z, flag_c, flag_v, busy, done, err, alu_clr}, 0);
    checkOutput("reset_drive", {alu_a, alu_b, alu_cin, strobes, dec_en, sboa, adloa}, 0);

    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    checkOutput("init_alu_clr", {alu_clr, busy}, 2'b11);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("init_clr_once", {alu_clr, busy}, 0);
    @(posedge clk); #1;
    checkOutput("start_in_init_ignored", busy, 0);

    applyStimulus(3'd0, 1'b0, 8'h35, 8'h27, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'd1, 1'b0, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'd0, 1'b1, 8'h15, 8'h27, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd5, 1'b0, 8'h81, 8'hFF, 1'b0, 1'b1, 1'b0);
    applyStimulus(3'd2, 1'b0, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd6, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'd7, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd4, 1'b0, 8'h0C, 8'h30, 1'b0, 1'b1, 1'b1);
    applyStimulus(3'd0, 1'b0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd1, 1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rOp  = 3'($urandom_range(0, 7));
      rDec = 1'($urandom);
      rA   = 8'($urandom);
      rB   = 8'($urandom);
      if (rOp == 3'd0 && rDec) begin
        rA = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        rB = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      applyStimulus(rOp, rDec, rA, rB, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    op = 3'd0; dec = 1'b0; a_val = 8'h11; b_val = 8'h22; dst_sel = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("abort_in_read", sboa, 1);
    #2;
    reset = 1'b0;
    #1;
    mRes = 8'h00; mN = 1'b0; mZ = 1'b0; mC = 1'b0; mV = 1'b0;
    checkOutput("abort_reset_outputs",
                {result, flag_n, flag_z, flag_c, flag_v, busy, done, err, alu_clr, sboa}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_reinit_clr", {alu_clr, done}, 2'b10);
    @(posedge clk); #1;
    checkOutput("abort_no_done", {done, busy, alu_clr}, 0);
    @(posedge clk); #1;
    checkOutput("abort_still_idle", {done, busy}, 0);

    applyStimulus(3'd3, 1'b0, 8'hAA, 8'h55, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
